// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c_master arbiter slice: command field widths,
// speed-mode codes and the arbiter FSM encoding.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [1:0] SPEED_100K = 2'b00;
  localparam logic [1:0] SPEED_400K = 2'b01;
  localparam logic [1:0] SPEED_1M   = 2'b10;
  localparam logic [1:0] SPEED_3M4  = 2'b11;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_RESPOND   = 2'd3;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping past the top.
module i2c_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // One extra bit on the sum keeps the wrap correct for non-power-of-two NUM_REQ.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters: round-robin grant, timed
// strobe issue, synchronised completion and per-requester response.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int HOLD_CYCLES    = 2048,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rnw,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  input  logic [2*NUM_REQ-1:0]      req_speed,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_ack_err,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic                      m_write,
  output logic                      m_read,
  output logic [1:0]                m_speed_mode,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_data_wr,
  input  logic [DATA_W-1:0]         m_data_rd,
  input  logic                      m_done,
  input  logic                      m_ack_error
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

  logic [1:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] cur_gnt;
  logic               cur_rnw;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  logic done_s1, sync_done, done_d;
  logic ack_s1, sync_ack_error;
  logic done_rise;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               sel_rnw;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [1:0]         sel_speed;

  // done/ack_error come from the master's divided-clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_s1        <= 1'b0;
      sync_done      <= 1'b0;
      done_d         <= 1'b0;
      ack_s1         <= 1'b0;
      sync_ack_error <= 1'b0;
    end else begin
      done_s1        <= m_done;
      sync_done      <= done_s1;
      done_d         <= sync_done;
      ack_s1         <= m_ack_error;
      sync_ack_error <= ack_s1;
    end
  end

  assign done_rise = sync_done & ~done_d;

  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req),
    .ptr       (ptr),
    .gnt       (pick_gnt),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  assign sel_rnw   = req_rnw[pick_idx];
  assign sel_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
  assign sel_speed = req_speed[int'(pick_idx)*2 +: 2];

  // The timeout counter runs from gnt; a done_rise seen during ISSUE is the
  // master's stale done level and is deliberately not looked at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      cur_gnt      <= '0;
      cur_rnw      <= 1'b0;
      hold_cnt     <= '0;
      tmo_cnt      <= '0;
      gnt          <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_ack_err  <= 1'b0;
      rsp_timeout  <= 1'b0;
      busy         <= 1'b0;
      m_write      <= 1'b0;
      m_read       <= 1'b0;
      m_speed_mode <= SPEED_100K;
      m_addr       <= '0;
      m_data_wr    <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt          <= pick_gnt;
            cur_gnt      <= pick_gnt;
            cur_rnw      <= sel_rnw;
            m_addr       <= sel_addr;
            m_data_wr    <= sel_wdata;
            m_speed_mode <= sel_speed;
            m_write      <= ~sel_rnw;
            m_read       <= sel_rnw;
            busy         <= 1'b1;
            ptr          <= (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
            hold_cnt     <= '0;
            tmo_cnt      <= '0;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            m_write <= 1'b0;
            m_read  <= 1'b0;
            state   <= ST_WAIT_DONE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (done_rise) begin
            rsp_valid   <= cur_gnt;
            rsp_rdata   <= cur_rnw ? m_data_rd : '0;
            rsp_ack_err <= sync_ack_error;
            rsp_timeout <= 1'b0;
            state       <= ST_RESPOND;
          end else if (tmo_cnt >= TMO_LAST) begin
            rsp_valid   <= cur_gnt;
            rsp_rdata   <= '0;
            rsp_ack_err <= 1'b0;
            rsp_timeout <= 1'b1;
            state       <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          busy        <= 1'b0;
          rsp_rdata   <= '0;
          rsp_ack_err <= 1'b0;
          rsp_timeout <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: directed table, reset corner case and randomized
// traffic against a slave/master model and a round-robin reference.
module tb_i2c_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int TMO  = 5000;

  typedef struct {
    logic [3:0] req;
    bit         hold;
    bit         rnw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [1:0] speed;
    bit         mute;
    int         idx;
    logic [7:0] exp_rdata;
    bit         exp_ack;
    bit         exp_tmo;
  } vec_t;

  logic        clk, rst;
  logic [3:0]  req, req_rnw;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_speed;
  logic [3:0]  gnt, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_ack_err, rsp_timeout, busy, m_write, m_read;
  logic [1:0]  m_speed_mode;
  logic [6:0]  m_addr;
  logic [7:0]  m_data_wr, m_data_rd;
  logic        m_done, m_ack_error;

  logic [6:0] slot_addr[4];
  logic [7:0] slot_wdata[4];
  logic [1:0] slot_speed[4];
  bit         mute;
  int         errors, checks, model_ptr;
  vec_t       vecs[11];

  i2c_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_speed(req_speed), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_ack_err(rsp_ack_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .m_write(m_write), .m_read(m_read), .m_speed_mode(m_speed_mode),
    .m_addr(m_addr), .m_data_wr(m_data_wr), .m_data_rd(m_data_rd),
    .m_done(m_done), .m_ack_error(m_ack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_speed = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7]  = slot_addr[i];
      req_wdata[8*i +: 8] = slot_wdata[i];
      req_speed[2*i +: 2] = slot_speed[i];
    end
  end

  function automatic logic [7:0] rdata_of(input logic [6:0] a);
    return {1'b0, a} ^ 8'h66;
  endfunction

  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Slave+master model: stale done blip early, real completion well after the hold window.
  initial begin
    logic [6:0] t_addr;
    logic       t_rnw, nack;
    m_done = 1'b0; m_ack_error = 1'b0; m_data_rd = 8'h00;
    forever begin
      @(negedge clk);
      if (m_write || m_read) begin
        t_addr = m_addr;
        t_rnw  = m_read;
        m_done = 1'b0;
        repeat (4) @(negedge clk);
        m_done = 1'b1;
        repeat (6) @(negedge clk);
        m_done = 1'b0;
        repeat ($urandom_range(10, 30)) @(negedge clk);
        if (!mute) begin
          nack        = (t_addr == 7'h21);
          m_ack_error = nack;
          m_data_rd   = (t_rnw && !nack) ? rdata_of(t_addr) : 8'h00;
          m_done      = 1'b1;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 5ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < N; i++) begin
      if (i == v.idx) begin
        req_rnw[i] = v.rnw; slot_addr[i] = v.addr;
        slot_wdata[i] = v.wdata; slot_speed[i] = v.speed;
      end else begin
        req_rnw[i] = ~v.rnw; slot_addr[i] = ~v.addr;
        slot_wdata[i] = ~v.wdata; slot_speed[i] = ~v.speed;
      end
    end
    mute = v.mute;
    req  = v.req;
  endtask

  task automatic runTxn(input vec_t v);
    logic [3:0] onehot;
    int wr_cnt, rd_cnt, lat;
    bit got, bad;
    onehot = 4'b0001 << v.idx;
    applyStimulus(v);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (gnt != 4'b0000) got = 1'b1;
    end
    if (!got) begin
      checkOutput("gnt_wait", 64'(gnt), 64'(onehot));
      req = '0;
      return;
    end
    checkOutput("gnt", gnt, onehot);
    checkOutput("busy_at_gnt", busy, 1);
    checkOutput("m_fields", {m_addr, m_data_wr, m_speed_mode}, {v.addr, v.wdata, v.speed});
    checkOutput("strobe_at_gnt", {m_write, m_read}, v.rnw ? 2'b01 : 2'b10);
    if (!v.hold) req = '0;
    wr_cnt = int'(m_write); rd_cnt = int'(m_read);
    lat = 0; got = 1'b0; bad = 1'b0;
    while (!got && lat < TMO + 200) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != 4'b0000) got = 1'b1;
      else begin
        wr_cnt += int'(m_write);
        rd_cnt += int'(m_read);
        if (busy !== 1'b1 || gnt !== 4'b0000 || m_addr !== v.addr || (m_write && m_read)) bad = 1'b1;
      end
    end
    checkOutput("busy_hold_fields_stable", bad, 0);
    checkOutput("rsp_valid", rsp_valid, onehot);
    if (!got) return;
    checkOutput("rsp_rdata", rsp_rdata, v.exp_rdata);
    checkOutput("rsp_ack_err", rsp_ack_err, v.exp_ack);
    checkOutput("rsp_timeout", rsp_timeout, v.exp_tmo);
    checkOutput("busy_at_rsp", busy, 1);
    checkOutput("write_hold", wr_cnt, v.rnw ? 0 : HOLD);
    checkOutput("read_hold", rd_cnt, v.rnw ? HOLD : 0);
    if (v.exp_tmo) checkOutput("timeout_latency", lat, TMO);
    @(negedge clk);
    checkOutput("after_rsp", {rsp_valid, busy}, 5'b0);
    model_ptr = (v.idx + 1) % N;
  endtask

  initial begin
    vec_t v;
    int idx, tmo_budget;
    bit got, bad;
    errors = 0; checks = 0; model_ptr = 0; mute = 1'b0;
    rst = 1'b0; req = '0; req_rnw = '0;
    for (int i = 0; i < N; i++) begin
      slot_addr[i] = '0; slot_wdata[i] = '0; slot_speed[i] = '0;
    end

    vecs[0]  = '{4'b1111, 1, 0, 7'h30, 8'h10, 2'b00, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{4'b1111, 1, 0, 7'h31, 8'h11, 2'b01, 0, 1, 8'h00, 0, 0};
    vecs[2]  = '{4'b1111, 1, 1, 7'h32, 8'h12, 2'b10, 0, 2, 8'h54, 0, 0};
    vecs[3]  = '{4'b1111, 1, 0, 7'h33, 8'h13, 2'b11, 0, 3, 8'h00, 0, 0};
    vecs[4]  = '{4'b1111, 0, 0, 7'h34, 8'h14, 2'b00, 0, 0, 8'h00, 0, 0};
    vecs[5]  = '{4'b0001, 0, 0, 7'h50, 8'hA5, 2'b01, 0, 0, 8'h00, 0, 0};
    vecs[6]  = '{4'b0100, 0, 1, 7'h3C, 8'h00, 2'b10, 0, 2, 8'h5A, 0, 0};
    vecs[7]  = '{4'b0010, 0, 0, 7'h21, 8'h33, 2'b00, 0, 1, 8'h00, 1, 0};
    vecs[8]  = '{4'b1000, 0, 0, 7'h44, 8'h99, 2'b01, 1, 3, 8'h00, 0, 1};
    vecs[9]  = '{4'b0100, 0, 1, 7'h11, 8'h00, 2'b11, 0, 2, 8'h77, 0, 0};
    vecs[10] = '{4'b0110, 0, 1, 7'h21, 8'h00, 2'b01, 0, 1, 8'h00, 1, 0};

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
      {gnt, rsp_valid, rsp_rdata, rsp_ack_err, rsp_timeout, busy, m_write, m_read,
       m_speed_mode, m_addr, m_data_wr}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 11; t++) runTxn(vecs[t]);

    // Reset while the arbiter waits for a done that never comes.
    v = '{4'b0010, 0, 1, 7'h2A, 8'h00, 2'b01, 1, 1, 8'h00, 0, 0};
    applyStimulus(v);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (gnt != 4'b0000) got = 1'b1;
    end
    checkOutput("rst_case_gnt", gnt, 4'b0010);
    req = '0;
    repeat (HOLD + 10) @(negedge clk);
    checkOutput("rst_case_waiting", {busy, m_write, m_read, rsp_valid}, 7'b1000000);
    #2 rst = 1'b0;
    #1 checkOutput("rst_async_clear",
      {gnt, rsp_valid, rsp_rdata, rsp_ack_err, rsp_timeout, busy, m_write, m_read,
       m_speed_mode, m_addr, m_data_wr}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_ptr = 0;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid != 4'b0000 || busy) bad = 1'b1;
    end
    checkOutput("no_rsp_after_rst", bad, 0);
    mute = 1'b0;
    runTxn('{4'b1000, 0, 0, 7'h0F, 8'hC3, 2'b10, 0, 3, 8'h00, 0, 0});
    runTxn('{4'b1011, 0, 1, 7'h3C, 8'h00, 2'b01, 0, 0, 8'h5A, 0, 0});

    // Randomized traffic against the round-robin reference.
    tmo_budget = 2;
    for (int r = 0; r < 30; r++) begin
      v.req   = 4'($urandom_range(1, 15));
      v.hold  = 1'b0;
      v.rnw   = 1'($urandom_range(0, 1));
      v.addr  = ($urandom_range(0, 4) == 0) ? 7'h21 : 7'($urandom_range(0, 127));
      v.wdata = 8'($urandom_range(0, 255));
      v.speed = 2'($urandom_range(0, 3));
      v.mute  = 1'b0;
      if (tmo_budget > 0 && $urandom_range(0, 14) == 0) begin
        v.mute = 1'b1;
        tmo_budget--;
      end
      idx = model_pick(v.req, model_ptr);
      v.idx       = idx;
      v.exp_tmo   = v.mute;
      v.exp_ack   = !v.mute && (v.addr == 7'h21);
      v.exp_rdata = (!v.mute && v.rnw && v.addr != 7'h21) ? rdata_of(v.addr) : 8'h00;
      runTxn(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
- Shares one i2c_master between NUM_REQ independent requesters (sensor pollers, config loaders, CPU bridge).
- Accepts single-byte read/write commands and grants round-robin.
- Drives the master's write/read strobes with a bounded hold window, waits for the master's done, and returns read data or error status to the granted requester.
- Runs on the system clock. The master's done/ack_error come from its divided-clock domain and are synchronised here.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 2048, clk cycles the write/read strobe is held; must exceed one i2c_clk period at the slowest speed (2*(SYS_CLK/DATA_RATE0+1)) and be shorter than one byte transfer.
- TIMEOUT_CYCLES, 2_000_000, clk cycles allowed from issue to done before declaring a timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- req  in  NUM_REQ  per-requester command request (level, held until gnt)
- req_rnw  in  NUM_REQ  1 = read, 0 = write, per requester
- req_addr  in  7*NUM_REQ  slave address, requester i at [7i+6:7i]
- req_wdata  in  8*NUM_REQ  write byte, requester i at [8i+7:8i]
- req_speed  in  2*NUM_REQ  speed_mode per requester (00 100k, 01 400k, 10 1M, 11 3.4M)
- gnt  out  NUM_REQ  one-cycle one-hot pulse: command accepted
- rsp_valid  out  NUM_REQ  one-cycle one-hot pulse: command complete
- rsp_rdata  out  8  read byte; valid with rsp_valid
- rsp_ack_err  out  1  slave NACK; valid with rsp_valid
- rsp_timeout  out  1  no done within TIMEOUT_CYCLES; valid with rsp_valid
- busy  out  1  high from gnt until rsp_valid inclusive
- m_write, m_read  out  1  strobes to i2c_master
- m_speed_mode  out  2 | m_addr  out  7 | m_data_wr  out  8  master command fields
- m_data_rd  in  8 | m_done  in  1 | m_ack_error  in  1  master results

Behaviour:
- Reset: every output 0; rr pointer = 0; state IDLE; counters 0; sync flops 0.
- m_done and m_ack_error pass through 2-flop synchronisers. done_rise = sync_done & ~done_d.
- FSM states are IDLE, ISSUE, WAIT_DONE and RESPOND.
- IDLE: if any req bit is set, pick the first set bit at or after the rr pointer, wrapping.
  - Latch that requester's rnw/addr/wdata/speed into the m_* fields.
  - Pulse gnt[i] and set busy. Pointer becomes i+1 mod NUM_REQ. Go to ISSUE.
- ISSUE: m_write = ~rnw, m_read = rnw, held HOLD_CYCLES cycles, then both drop to 0. Go to WAIT_DONE.
  - Timeout counter starts at gnt.
  - A done_rise during ISSUE is ignored: it is the stale level from the master's IDLE clear.
- WAIT_DONE: on done_rise, capture m_data_rd and sync_ack_error and go to RESPOND.
  - If the timeout counter reaches TIMEOUT_CYCLES first, set the timeout flag and go to RESPOND.
  - done_rise and timeout in the same cycle: done wins, timeout = 0.
- RESPOND (1 cycle):
  - Pulse rsp_valid[i] with rsp_rdata (read only, else 0), rsp_ack_err and rsp_timeout. Clear busy.
  - Go to IDLE. A new grant is possible on the next cycle.
- m_addr, m_speed_mode and m_data_wr stay stable from gnt through RESPOND, so the speed divider never changes mid-transfer.
- Requests dropped before gnt are lost without response. req[i] held after rsp_valid is treated as a new command.
- Fairness: with all NUM_REQ requesting, grants cycle 0,1,...,NUM_REQ-1, 0, ...
- rst low mid-transfer: all outputs clear immediately and no rsp is issued. The master must be reset by the same rst.

Decomposition:
- Shared package i2c_pkg:
  - speed_mode constants (SPEED_100K..SPEED_3M4)
  - arbiter state encoding
  - command field widths (ADDR_W = 7, DATA_W = 8)
- One natural sub-module: i2c_rr_arbiter. It is a combinational-plus-pointer round-robin picker taking req and ptr, and returning the one-hot grant and its index.

Test Plan:
- Req0 write addr 0x50, data 0xA5, speed 01 → gnt[0] pulse; m_write high exactly HOLD_CYCLES; m_addr=0x50; after slave-model ACK, rsp_valid[0] with ack_err=0, timeout=0.
- Req2 read addr 0x3C, model returns 0x5A → m_read high HOLD_CYCLES then 0; rsp_valid[2] with rsp_rdata=0x5A; only one byte is read (no repeated RD_DATA loop).
- req=4'b1111 held continuously → grant order 0,1,2,3,0; never two gnt bits set; busy never drops between gnt and rsp_valid.
- Slave model NACKs address 0x21 → rsp_valid[1] with rsp_ack_err=1, rsp_rdata=0x00.
- m_done tied 0, TIMEOUT_CYCLES=5000 → rsp_valid at gnt+5000(+1) with rsp_timeout=1; arbiter then serves the next request.
- rst asserted in WAIT_DONE → all outputs 0 asynchronously; after release, a fresh req3 is granted first, since the pointer resets to 0 and the scan wraps to 3.
